// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// parity modes and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } txState_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clock cycles occupied by one complete frame, start bit through last stop bit.
    function automatic int frameLength(input int dataBits, input int parity,
                                       input int stopBits, input int clksPerBit);
        return (1 + dataBits + ((parity != PAR_NONE) ? 1 : 0) + stopBits) * clksPerBit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is ignored when full,
// pop is ignored when empty, and the head word is always visible on dout.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_1MHz,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (level == (AW + 1)'(DEPTH));
    assign empty  = (level == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            level <= level + (AW + 1)'(doPush) - (AW + 1)'(doPop);
        end
    end

    always_ff @(posedge clk_1MHz) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back while
// words are queued, and the line idles high otherwise.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_1MHz,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DATA_BITS-1:0]          inData,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    txState_e             state, stateNext;
    logic [15:0]          bitCnt, cntNext;
    logic [3:0]           bitIdx, idxNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic                 parBit, parNext;
    logic                 txNext, busyNext;
    logic                 fifoPop, fifoFull, fifoEmpty, startFrame, lastTick;
    logic [DATA_BITS-1:0] fifoDout;

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) fifo (
        .clk_1MHz(clk_1MHz),
        .rst     (rst),
        .push    (load),
        .pop     (fifoPop),
        .din     (inData),
        .dout    (fifoDout),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .level   (level)
    );

    assign ready    = !fifoFull;
    assign lastTick = (bitCnt == 16'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            parBit   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= cntNext;
            bitIdx   <= idxNext;
            shiftReg <= shiftNext;
            parBit   <= parNext;
            tx       <= txNext;
            busy     <= busyNext;
        end
    end

    // tx is registered, so each transition loads the value of the bit being entered.
    always_comb begin
        stateNext  = state;
        cntNext    = bitCnt + 16'd1;
        idxNext    = bitIdx;
        shiftNext  = shiftReg;
        parNext    = parBit;
        txNext     = tx;
        busyNext   = busy;
        fifoPop    = 1'b0;
        startFrame = 1'b0;

        case (state)
            ST_IDLE: begin
                cntNext = '0;
                idxNext = '0;
                if (!fifoEmpty) startFrame = 1'b1;
            end
            ST_START: begin
                if (lastTick) begin
                    stateNext = ST_DATA;
                    cntNext   = '0;
                    idxNext   = '0;
                    txNext    = shiftReg[0];
                end
            end
            ST_DATA: begin
                if (lastTick) begin
                    cntNext   = '0;
                    shiftNext = shiftReg >> 1;
                    if (bitIdx == 4'(DATA_BITS - 1)) begin
                        idxNext = '0;
                        if (PARITY != PAR_NONE) begin
                            stateNext = ST_PARITY;
                            txNext    = parBit;
                        end else begin
                            stateNext = ST_STOP;
                            txNext    = 1'b1;
                        end
                    end else begin
                        idxNext = bitIdx + 4'd1;
                        txNext  = shiftReg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (lastTick) begin
                    stateNext = ST_STOP;
                    cntNext   = '0;
                    idxNext   = '0;
                    txNext    = 1'b1;
                end
            end
            ST_STOP: begin
                if (lastTick) begin
                    cntNext = '0;
                    if (bitIdx == 4'(STOP_BITS - 1)) begin
                        idxNext = '0;
                        if (!fifoEmpty) begin
                            startFrame = 1'b1;
                        end else begin
                            stateNext = ST_IDLE;
                            txNext    = 1'b1;
                            busyNext  = 1'b0;
                        end
                    end else begin
                        idxNext = bitIdx + 4'd1;
                    end
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // Shared by the idle pickup and the back-to-back path out of the last stop bit.
        if (startFrame) begin
            fifoPop   = 1'b1;
            stateNext = ST_START;
            cntNext   = '0;
            idxNext   = '0;
            shiftNext = fifoDout;
            parNext   = (PARITY == PAR_EVEN) ? ^fifoDout : ~^fifoDout;
            txNext    = 1'b0;
            busyNext  = 1'b1;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, 8, data bits per frame; legal range 5..9.
REQ-002 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
REQ-004 Parameter CLKS_PER_BIT, 104, clk_1MHz cycles per bit (9600 baud); legal range 2..65535.
REQ-005 Parameter FIFO_DEPTH, 4, number of queued words; power of 2, legal range 2..64.
REQ-006 Port clk_1MHz  input  1  sole clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  asynchronous, active-low reset.
REQ-008 Port load  input  1  write strobe; pushes inData when ready=1.
REQ-009 Port inData  input  DATA_BITS  word to transmit.
REQ-010 Port ready  output  1  high when FIFO not full.
REQ-011 Port tx  output  1  serial line, idle high, registered.
REQ-012 Port busy  output  1  high while a frame is on the line (START through last STOP).
REQ-013 Port level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A push shall occur on a rising edge where load=1 and ready=1; load while ready=0 shall be ignored with no state change.
REQ-015 Frame shall be: START (0), DATA_BITS data bits LSB first, parity bit if PARITY!=0, STOP_BITS stop bits (1).
REQ-016 Each bit shall drive tx for exactly CLKS_PER_BIT cycles; frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-017 Parity bit: even mode = XOR of data bits; odd mode = its inverse; computed from the popped word.
REQ-018 State machine states IDLE, START, DATA, PARITY, STOP; bit-period counter and bit index counter reset to 0 on each state entry.
REQ-019 IDLE -> START on the edge where level!=0: pop head into shift register; tx=0 and busy=1 from that edge.
REQ-020 START -> DATA, DATA -> PARITY (or STOP if PARITY=0) after DATA_BITS periods, PARITY -> STOP, each at end of its final bit period.
REQ-021 At end of last STOP period: if level!=0 pop and go directly to START (back-to-back, no idle cycle); else go to IDLE, busy=0, tx=1.
REQ-022 Latency: load accepted into empty FIFO at edge T, transmitter IDLE -> pop at edge T+1, start bit begins at T+1.
REQ-023 Simultaneous push and pop shall leave level unchanged; ready is computed from registered level (a pop does not re-enable ready until the following cycle).
REQ-024 Push when full is dropped; pop when empty never occurs; read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 level shall never exceed FIFO_DEPTH nor underflow.

Reset
REQ-026 rst=0 shall immediately force: state IDLE, tx=1, busy=0, ready=1, level=0, pointers and counters 0.
REQ-027 Reset asserted mid-frame shall abort the frame and discard FIFO contents; tx returns high asynchronously.
REQ-028 After rst deasserts, no frame shall start until a new push.

Structure
REQ-029 Shared package uart_pkg shall hold state encoding constants, parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a frame-length function.
REQ-030 FIFO shall be a separate sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level), instantiated once.

Verification
REQ-031 Defaults (8N1, 104): push 0x96 -> tx 0,0,1,1,0,1,0,0,1,1 each 104 cycles; busy high 1040 cycles; start bit 1 cycle after load edge.
REQ-032 PARITY=1: push 0x07 -> parity bit 1; PARITY=2: push 0x07 -> parity bit 0; frame 1144 cycles.
REQ-033 Push 0x96, 0x35 on consecutive cycles -> frames back-to-back, no idle gap, tx stop bit of frame 1 immediately followed by start bit of frame 2.
REQ-034 Push 6 words with FIFO_DEPTH=4 while frame 1 active -> ready=0 after 5th accepted (1 in shift reg + 4 queued), 6th dropped, 5 frames transmitted.
REQ-035 Assert rst at cycle 300 of a frame -> tx=1, busy=0, level=0 immediately; no further frames after release.
REQ-036 DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=4: push 0x15 -> tx 0,1,0,1,0,1,1,1 each 4 cycles, busy 32 cycles.
